vertical_position_ctrl: RTL and testbench

Per-frame vertical motion engine for the helicopter sprite. Consumes the increase/decrease direction pair from the direction flip-flop and steps a saturating y-coordinate once per game tick. Issues erase-then-draw requests to the pixel plotter. Produces the high/low boundary flags that feed back into the direction flip-flop, closing the bounce loop.

---
 rtl/vertical_position_ctrl.sv | 163 ++++++++++++++++
 tb/tb_vertical_position_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertical_position_ctrl.sv
// Purpose : per-tick vertical motion for the helicopter sprite; saturating y step plus an
//           erase-then-draw request pair to the pixel plotter, and high/low bounce flags.
// Latency : tick -> plot_req rise 2 cycles; erase draw_ack -> draw plot_req rise 2 cycles.
// Backpr. : plot_req is held until draw_ack; ticks arriving while one is pending are dropped.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   enable                 game running; low freezes motion and clears the pending tick
//   increase / decrease    direction from the bounce flip-flop, sampled in the MOVE cycle only
//   draw_ack               one-cycle completion pulse from the plotter
//   y_pos                  current sprite row
//   plot_y, plot_erase     row and colour select (1 = background) of the current request
//   plot_req               plot request, held until draw_ack
//   high / low             registered flags: y_pos at top / bottom boundary
module vertical_position_ctrl #(
    parameter int Y_W      = 7,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 119,
    parameter int Y_INIT   = 60,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 833333,
    parameter int CNT_W    = 20
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           increase,
    input  logic           decrease,
    input  logic           draw_ack,
    output logic [Y_W-1:0] y_pos,
    output logic [Y_W-1:0] plot_y,
    output logic           plot_erase,
    output logic           plot_req,
    output logic           high,
    output logic           low
);

    localparam int YE_W = Y_W + 1;

    // One extra bit so y + STEP cannot wrap before the bottom clamp is applied.
    localparam logic [YE_W-1:0] MAX_E    = YE_W'(Y_MAX);
    localparam logic [YE_W-1:0] STEP_E   = YE_W'(STEP);
    localparam logic [YE_W-1:0] FLOOR_E  = YE_W'(Y_MIN + STEP);
    localparam logic [Y_W-1:0]  MIN_Y    = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]  MAX_Y    = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]  INIT_Y   = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0]  STEP_Y   = Y_W'(STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        MOVE  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             tick_pending;
    logic             start;

    logic [YE_W-1:0]  y_ext;
    logic [YE_W-1:0]  y_up;
    logic [Y_W-1:0]   y_dn;
    logic [Y_W-1:0]   y_next;

    // A tick is the cycle in which the divider wraps.
    assign tick  = enable && (tick_cnt == CNT_LAST);

    // Starts are also gated by enable so a tick latched just before enable fell
    // cannot begin a new erase/draw pair while the game is frozen.
    assign start = (state == IDLE) && tick_pending && enable;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    // Single-entry pending flag: a fresh tick wins over consumption in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_pending <= 1'b0;
        end else if (!enable) begin
            tick_pending <= 1'b0;
        end else if (tick) begin
            tick_pending <= 1'b1;
        end else if (start) begin
            tick_pending <= 1'b0;
        end
    end

    // Saturating next row; the decrement is only taken when it cannot pass Y_MIN.
    always_comb begin
        y_ext  = {1'b0, y_pos};
        y_up   = y_ext + STEP_E;
        y_dn   = y_pos - STEP_Y;
        y_next = y_pos;
        if (increase && !decrease) begin
            y_next = (y_up > MAX_E) ? MAX_Y : y_up[Y_W-1:0];
        end else if (decrease && !increase) begin
            y_next = (y_ext < FLOOR_E) ? MIN_Y : y_dn;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            y_pos      <= INIT_Y;
            plot_y     <= INIT_Y;
            plot_erase <= 1'b0;
            plot_req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        plot_y     <= y_pos;
                        plot_erase <= 1'b1;
                        plot_req   <= 1'b1;
                        state      <= ERASE;
                    end
                end
                ERASE: begin
                    if (draw_ack) begin
                        plot_req <= 1'b0;
                        state    <= MOVE;
                    end
                end
                MOVE: begin
                    y_pos      <= y_next;
                    plot_y     <= y_next;
                    plot_erase <= 1'b0;
                    plot_req   <= 1'b1;
                    state      <= DRAW;
                end
                DRAW: begin
                    if (draw_ack) begin
                        plot_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flags trail y_pos by one cycle; Y_MIN < Y_MAX keeps them mutually exclusive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            high <= 1'b0;
            low  <= 1'b0;
        end else begin
            high <= (y_pos <= MIN_Y);
            low  <= (y_pos >= MAX_Y);
        end
    end

endmodule

// File: tb/tb_vertical_position_ctrl.sv
// Purpose : self-checking bench for vertical_position_ctrl (two instances run in lockstep:
//           STEP=1/Y_INIT=60 and STEP=3/Y_INIT=1), directed table, hand sequences, random phase.
// Latency : n/a.  Backpressure: bench drives draw_ack with fixed or random delays.
module tb_vertical_position_ctrl;

    localparam int YMIN = 0;
    localparam int YMAX = 119;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       inc;
    logic       dec;
    logic       ack;
    logic [6:0] y_v  [2];
    logic [6:0] py_v [2];
    logic       req_v[2];
    logic       er_v [2];
    logic       hi_v [2];
    logic       lo_v [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state per instance.
    int model_y  [2];
    bit prev_req [2];
    bit prev_er  [2];
    int prev_py  [2];
    bit move_pend[2];

    typedef struct {
        logic en, inc, dec, ack;
        logic req, er;
        int   py, y;
        logic hi, lo;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    vertical_position_ctrl #(
        .Y_W(7), .Y_MIN(YMIN), .Y_MAX(YMAX), .Y_INIT(60), .STEP(1), .TICK_DIV(4), .CNT_W(20)
    ) dut_a (
        .clk(clk), .resetn(resetn), .enable(enable), .increase(inc), .decrease(dec),
        .draw_ack(ack), .y_pos(y_v[0]), .plot_y(py_v[0]), .plot_erase(er_v[0]),
        .plot_req(req_v[0]), .high(hi_v[0]), .low(lo_v[0])
    );

    vertical_position_ctrl #(
        .Y_W(7), .Y_MIN(YMIN), .Y_MAX(YMAX), .Y_INIT(1), .STEP(3), .TICK_DIV(4), .CNT_W(20)
    ) dut_b (
        .clk(clk), .resetn(resetn), .enable(enable), .increase(inc), .decrease(dec),
        .draw_ack(ack), .y_pos(y_v[1]), .plot_y(py_v[1]), .plot_erase(er_v[1]),
        .plot_req(req_v[1]), .high(hi_v[1]), .low(lo_v[1])
    );

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int init_of(input int i);
        return (i == 0) ? 60 : 1;
    endfunction

    function automatic int mv(input int y, input bit up, input bit dn, input int step);
        if (up && !dn) return (y + step > YMAX) ? YMAX : y + step;
        if (dn && !up) return (y - step < YMIN) ? YMIN : y - step;
        return y;
    endfunction

    function automatic vec_t row(input logic en, input logic ai, input logic ad, input logic ak,
                                 input logic rq, input logic er, input int py, input int y);
        vec_t r;
        r.en = en; r.inc = ai; r.dec = ad; r.ack = ak;
        r.req = rq; r.er = er; r.py = py; r.y = y; r.hi = 1'b0; r.lo = 1'b0;
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            model_y[i]   = init_of(i);
            prev_req[i]  = 1'b0;
            prev_er[i]   = 1'b0;
            prev_py[i]   = init_of(i);
            move_pend[i] = 1'b0;
        end
    endtask

    // Called just after every active edge: the applied inputs are those the DUT just sampled.
    task automatic monitor();
        for (int i = 0; i < 2; i++) begin
            int oldy;
            bit nmove;
            oldy  = model_y[i];
            nmove = prev_req[i] && prev_er[i] && (ack == 1'b1);
            if (move_pend[i]) begin
                model_y[i] = mv(model_y[i], inc, dec, step_of(i));
                chk(req_v[i] == 1'b1, "draw_req_rise", int'(req_v[i]), 1);
                chk(er_v[i] == 1'b0, "draw_colour", int'(er_v[i]), 0);
                chk(int'(py_v[i]) == model_y[i], "draw_plot_y", int'(py_v[i]), model_y[i]);
            end else if (prev_req[i]) begin
                if (ack == 1'b1) begin
                    chk(req_v[i] == 1'b0, "ack_drops_req", int'(req_v[i]), 0);
                end else begin
                    chk(req_v[i] == 1'b1, "req_held", int'(req_v[i]), 1);
                    chk(int'(py_v[i]) == prev_py[i] && er_v[i] == prev_er[i], "req_stable",
                        int'(py_v[i]), prev_py[i]);
                end
            end else if (req_v[i]) begin
                chk(er_v[i] == 1'b1, "erase_colour", int'(er_v[i]), 1);
                chk(int'(py_v[i]) == model_y[i], "erase_plot_y", int'(py_v[i]), model_y[i]);
            end
            chk(int'(y_v[i]) == model_y[i], "y_pos", int'(y_v[i]), model_y[i]);
            chk(hi_v[i] == (oldy <= YMIN), "high_flag", int'(hi_v[i]), int'(oldy <= YMIN));
            chk(lo_v[i] == (oldy >= YMAX), "low_flag", int'(lo_v[i]), int'(oldy >= YMAX));
            move_pend[i] = nmove;
            prev_req[i]  = req_v[i];
            prev_er[i]   = er_v[i];
            prev_py[i]   = int'(py_v[i]);
        end
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        if (resetn) monitor();
        ack = 1'b0;
    endtask

    // One erase/draw pair on instance A (B runs in lockstep), acked dly cycles after each request.
    task automatic do_txn(input bit up, input bit dn, input int dly);
        int w;
        inc = up;
        dec = dn;
        w = 0;
        while (!(req_v[0] && er_v[0]) && w < 50) begin
            tick_cycle();
            w++;
        end
        if (w >= 50) chk(1'b0, "txn_erase_timeout", w, 0);
        repeat (dly) tick_cycle();
        ack = 1'b1;
        tick_cycle();
        w = 0;
        while (!(req_v[0] && !er_v[0]) && w < 50) begin
            tick_cycle();
            w++;
        end
        if (w >= 50) chk(1'b0, "txn_draw_timeout", w, 0);
        repeat (dly) tick_cycle();
        ack = 1'b1;
        tick_cycle();
    endtask

    initial begin
        int w;
        int hold_py;
        bit quiet;

        tbl[0]  = row(1, 1, 0, 0, 0, 0, 60, 60);
        tbl[1]  = row(1, 1, 0, 0, 0, 0, 60, 60);
        tbl[2]  = row(1, 1, 0, 0, 0, 0, 60, 60);
        tbl[3]  = row(1, 1, 0, 0, 0, 0, 60, 60);   // counter wraps: tick
        tbl[4]  = row(1, 1, 0, 0, 1, 1, 60, 60);   // erase request 2 cycles after tick
        tbl[5]  = row(1, 1, 0, 0, 1, 1, 60, 60);
        tbl[6]  = row(1, 1, 0, 0, 1, 1, 60, 60);
        tbl[7]  = row(1, 1, 0, 1, 0, 1, 60, 60);   // erase ack, MOVE next
        tbl[8]  = row(1, 1, 0, 0, 1, 0, 61, 61);   // draw at the new row
        tbl[9]  = row(1, 1, 0, 0, 1, 0, 61, 61);
        tbl[10] = row(1, 1, 0, 0, 1, 0, 61, 61);
        tbl[11] = row(1, 1, 0, 1, 0, 0, 61, 61);   // draw ack, back to IDLE
        tbl[12] = row(1, 1, 0, 0, 1, 1, 61, 61);   // pending tick starts next erase

        resetn = 1'b0;
        enable = 1'b0;
        inc    = 1'b0;
        dec    = 1'b0;
        ack    = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        chk(y_v[0] == 7'd60 && py_v[0] == 7'd60, "reset_y_a", int'(y_v[0]), 60);
        chk(y_v[1] == 7'd1, "reset_y_b", int'(y_v[1]), 1);
        chk(req_v[0] == 1'b0 && er_v[0] == 1'b0, "reset_req", int'(req_v[0]), 0);
        chk(hi_v[0] == 1'b0 && lo_v[0] == 1'b0, "reset_flags", int'({hi_v[0], lo_v[0]}), 0);
        resetn = 1'b1;

        // Directed cycle table on instance A.
        for (int r = 0; r < 13; r++) begin
            enable = tbl[r].en;
            inc    = tbl[r].inc;
            dec    = tbl[r].dec;
            ack    = tbl[r].ack;
            tick_cycle();
            chk(req_v[0] == tbl[r].req, $sformatf("tbl%0d_req", r), int'(req_v[0]), int'(tbl[r].req));
            chk(er_v[0] == tbl[r].er, $sformatf("tbl%0d_erase", r), int'(er_v[0]), int'(tbl[r].er));
            chk(int'(py_v[0]) == tbl[r].py, $sformatf("tbl%0d_plot_y", r), int'(py_v[0]), tbl[r].py);
            chk(int'(y_v[0]) == tbl[r].y, $sformatf("tbl%0d_y", r), int'(y_v[0]), tbl[r].y);
            chk(hi_v[0] == tbl[r].hi && lo_v[0] == tbl[r].lo, $sformatf("tbl%0d_flags", r),
                int'({hi_v[0], lo_v[0]}), int'({tbl[r].hi, tbl[r].lo}));
        end

        // Hold cases: back to 60, then both-high and both-low directions.
        do_txn(0, 1, 2);
        do_txn(1, 1, 1);
        do_txn(1, 1, 0);
        do_txn(0, 0, 3);
        do_txn(0, 0, 0);
        chk(y_v[0] == 7'd60, "hold_y", int'(y_v[0]), 60);
        chk(py_v[0] == 7'd60, "hold_plot_y", int'(py_v[0]), 60);
        chk(y_v[1] == 7'd1, "hold_y_b", int'(y_v[1]), 1);

        // Top saturation with STEP=3 from row 1.
        do_txn(0, 1, 1);
        chk(y_v[1] == 7'd0, "top_sat_y", int'(y_v[1]), 0);
        chk(hi_v[1] == 1'b1 && lo_v[1] == 1'b0, "top_high", int'({hi_v[1], lo_v[1]}), 2);
        chk(hi_v[0] == 1'b0, "mid_not_high", int'(hi_v[0]), 0);

        // Bottom saturation on both instances, then hold at the bottom.
        for (int k = 0; k < 63; k++) do_txn(1, 0, 0);
        chk(y_v[0] == 7'd119 && y_v[1] == 7'd119, "bottom_sat_y", int'(y_v[0]), 119);
        chk(lo_v[0] == 1'b1 && hi_v[0] == 1'b0, "bottom_low_a", int'({hi_v[0], lo_v[0]}), 1);
        chk(lo_v[1] == 1'b1, "bottom_low_b", int'(lo_v[1]), 1);
        do_txn(0, 1, 0);
        chk(y_v[0] == 7'd118 && y_v[1] == 7'd116, "leave_bottom", int'(y_v[1]), 116);
        chk(lo_v[0] == 1'b0 && lo_v[1] == 1'b0, "low_clears", int'(lo_v[0]), 0);

        // Random phase: directions, enable and ack (including stray acks) all random.
        for (int c = 0; c < 3000; c++) begin
            tick_cycle();
            inc    = 1'($urandom_range(0, 1));
            dec    = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 15) != 0);
            ack    = (req_v[0] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
        end

        // Withheld ack across many ticks: single pending entry.
        enable = 1'b1;
        ack    = 1'b0;
        w = 0;
        while (!(req_v[0] && er_v[0]) && w < 100) begin
            if (req_v[0]) ack = 1'b1;
            tick_cycle();
            w++;
        end
        chk(w < 100, "t5_wait_erase", w, 0);
        hold_py = int'(py_v[0]);
        repeat (40) tick_cycle();
        chk(req_v[0] && er_v[0] && int'(py_v[0]) == hold_py, "t5_held", int'(py_v[0]), hold_py);
        ack = 1'b1;
        tick_cycle();
        tick_cycle();
        chk(req_v[0] && !er_v[0], "t5_draw", int'({req_v[0], er_v[0]}), 2);
        ack = 1'b1;
        tick_cycle();
        chk(req_v[0] == 1'b0, "t5_idle_gap", int'(req_v[0]), 0);
        tick_cycle();
        chk(req_v[0] && er_v[0], "t5_pending_txn", int'({req_v[0], er_v[0]}), 3);
        enable = 1'b0;
        ack = 1'b1;
        tick_cycle();
        tick_cycle();
        ack = 1'b1;
        tick_cycle();
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick_cycle();
            if (req_v[0] || req_v[1]) quiet = 1'b0;
        end
        chk(quiet, "t5_no_further_txn", int'(quiet), 1);

        // Asynchronous reset in the middle of a draw request.
        enable = 1'b1;
        w = 0;
        while (!(req_v[0] && !er_v[0]) && w < 100) begin
            if (req_v[0]) ack = 1'b1;
            tick_cycle();
            w++;
        end
        chk(w < 100, "t6_wait_draw", w, 0);
        resetn = 1'b0;
        #1;
        chk(req_v[0] == 1'b0 && req_v[1] == 1'b0, "t6_req_drop", int'(req_v[0]), 0);
        chk(y_v[0] == 7'd60 && py_v[0] == 7'd60, "t6_y_a", int'(y_v[0]), 60);
        chk(y_v[1] == 7'd1, "t6_y_b", int'(y_v[1]), 1);
        reset_model();
        enable = 1'b0;
        tick_cycle();
        tick_cycle();
        resetn = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick_cycle();
            if (req_v[0] || req_v[1]) quiet = 1'b0;
        end
        chk(quiet, "t6_no_req_disabled", int'(quiet), 1);
        chk(y_v[0] == 7'd60, "t6_y_frozen", int'(y_v[0]), 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
